// File: rtl/instr_mem_responder_if.sv
// Fetch/load bus between a CPU front end and the instruction memory responder.
// The master side drives requests and program loads; the slave returns instruction words.
interface instr_mem_responder_if;
    logic [31:0] PC;
    logic        READ;
    logic [31:0] INSTRUCTION;
    logic        BUSYWAIT;
    logic        MISALIGNED;
    logic        LOAD_EN;
    logic [31:0] LOAD_ADDR;
    logic [7:0]  LOAD_DATA;

    modport master (
        output PC, READ, LOAD_EN, LOAD_ADDR, LOAD_DATA,
        input  INSTRUCTION, BUSYWAIT, MISALIGNED
    );

    modport slave (
        input  PC, READ, LOAD_EN, LOAD_ADDR, LOAD_DATA,
        output INSTRUCTION, BUSYWAIT, MISALIGNED
    );
endinterface

// File: rtl/instr_mem_responder.sv
// Byte-organised little-endian instruction memory with a fixed-latency fetch port
// and a byte-wide load port that only writes while the responder is idle.
module instr_mem_responder #(
    parameter int DEPTH_BYTES  = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    instr_mem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = $clog2(READ_LATENCY + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_addr;
    logic          r_mis;
    logic [31:0]   r_instruction;
    logic          r_busywait;
    logic          r_misaligned;
    logic [7:0]    r_mem [DEPTH_BYTES];

    logic          w_load;
    logic          w_accept;
    logic          w_complete;
    logic [31:0]   w_word;
    logic          w_unused;

    // Address bits above the storage size are deliberately dropped so the space wraps.
    assign w_unused = ^{bus.PC[31:AW], bus.LOAD_ADDR[31:AW]};

    assign w_word = {r_mem[{r_addr[AW-1:2], 2'd3}], r_mem[{r_addr[AW-1:2], 2'd2}],
                     r_mem[{r_addr[AW-1:2], 2'd1}], r_mem[{r_addr[AW-1:2], 2'd0}]};

    assign bus.INSTRUCTION = r_instruction;
    assign bus.BUSYWAIT    = r_busywait;
    assign bus.MISALIGNED  = r_misaligned;

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Loads win over fetches in IDLE; the fetch stays pending until the load drops.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.LOAD_EN) begin
                    w_load = 1'b1;
                end else if (bus.READ) begin
                    w_accept     = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_count == CW'(1)) begin
                    w_complete   = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count       <= '0;
            r_instruction <= 32'h0;
            r_busywait    <= 1'b0;
            r_misaligned  <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= {bus.PC[AW-1:2], 2'b00};
            r_mis      <= |bus.PC[1:0];
            r_count    <= CW'(READ_LATENCY);
            r_busywait <= 1'b1;
        end else if (r_state == S_WAIT) begin
            r_count <= r_count - CW'(1);
            if (w_complete) begin
                r_instruction <= w_word;
                r_misaligned  <= r_mis;
                r_busywait    <= 1'b0;
            end
        end
    end

    // Storage is never cleared; reset only blocks a write on its own edge.
    always_ff @(posedge CLK) begin
        if (!RESET && w_load) r_mem[bus.LOAD_ADDR[AW-1:0]] <= bus.LOAD_DATA;
    end

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Instruction-memory responder that sits on the other end of the CPU fetch interface: it accepts a 32-bit PC fetch request, waits a fixed access latency while holding BUSYWAIT, then returns the 32-bit instruction word. Storage is byte-organised and little-endian. A byte-wide load port lets the testbench or boot logic write the program image while the memory is idle. The CPU stalls its PC update while BUSYWAIT is high.

## Interface
- DEPTH_BYTES, 1024, storage size in bytes; power of two, at least 4.
- READ_LATENCY, 2, clock edges from request acceptance to data return; at least 1.
- AW, log2(DEPTH_BYTES), internal byte-address width (derived).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- PC  in  32  fetch byte address.
- READ  in  1  fetch request level.
- INSTRUCTION  out  32  returned instruction word, registered.
- BUSYWAIT  out  1  high while an access is in flight, registered.
- MISALIGNED  out  1  high with returned data when the latched PC[1:0] was nonzero, registered.
- LOAD_EN  in  1  byte write strobe.
- LOAD_ADDR  in  32  byte address for the load.
- LOAD_DATA  in  8  byte to write.

## Operation
- Reset, sampled at CLK: state=IDLE, INSTRUCTION=32'h0, BUSYWAIT=0, MISALIGNED=0, counter=0. Memory contents are not cleared.
- RESET has priority over everything. Asserting it mid-access aborts the access, and INSTRUCTION keeps its reset value of 0.
- States and transitions:
  - IDLE:
    - LOAD_EN=1: write mem[LOAD_ADDR[AW-1:0]] <= LOAD_DATA and stay in IDLE. Load has priority over READ; a simultaneous READ is not accepted and must be held.
    - LOAD_EN=0 and READ=1: accept the request. Latch addr <= {PC[AW-1:2],2'b00}, latch mis <= |PC[1:0], counter <= READ_LATENCY, BUSYWAIT <= 1, go to WAIT.
  - WAIT:
    - counter decrements each edge.
    - On the edge where counter==1:
      - INSTRUCTION <= {mem[addr+3], mem[addr+2], mem[addr+1], mem[addr]}.
      - MISALIGNED <= mis.
      - BUSYWAIT <= 0.
      - Go to IDLE.
    - READ, PC and LOAD_EN are ignored in WAIT. Loads in WAIT are dropped, not queued.
- Address arithmetic:
  - PC bits above AW-1 are ignored, so addresses wrap modulo DEPTH_BYTES.
  - addr+1..addr+3 never cross a word boundary because addr is word-aligned.
- Misaligned PC: the low two bits are forced to 0, the aligned word is returned, and MISALIGNED is set with it.
- INSTRUCTION and MISALIGNED hold their last values until the next completion or reset.

## Timing
- Request accepted at edge t (IDLE, READ=1, LOAD_EN=0):
  - BUSYWAIT is high after edge t.
  - INSTRUCTION is valid and BUSYWAIT is low after edge t+READ_LATENCY.
- Fetch latency is READ_LATENCY cycles. With READ held high, the next request is accepted on edge t+READ_LATENCY+1, giving one IDLE cycle between accesses. Throughput is 1 word per READ_LATENCY+1 cycles.
- Load is a single-cycle write. A READ accepted on the following edge sees the written byte.
- The BUSYWAIT falling edge and the INSTRUCTION update occur on the same edge, so the CPU may sample INSTRUCTION in the first cycle BUSYWAIT is low.
- No combinational path from any input to any output.

## Test plan
- Reset: hold RESET for 2 edges mid-WAIT -> INSTRUCTION=0, BUSYWAIT=0, MISALIGNED=0; the aborted access never completes.
- Load then fetch:
  - Load bytes 0x04,0x03,0x02,0x01 to addresses 0..3.
  - READ with PC=0 at edge t -> BUSYWAIT high over t..t+1, INSTRUCTION=32'h01020304 after t+2 (READ_LATENCY=2).
- Back-to-back:
  - Load PC 0 with word 32'h01020304 and PC 4 with word 32'h05000102.
  - Hold READ=1 and step PC 0 -> 4 on completion.
  - Expect the second acceptance exactly one cycle after the first completion, returning 32'h05000102.
- Wrap and misalign (DEPTH_BYTES=1024):
  - PC=32'h00000404 -> returns the word at 4.
  - PC=32'h00000006 -> returns the word at 4 with MISALIGNED=1.
- Load/READ collision and WAIT-time load:
  - LOAD_EN and READ both high in IDLE -> byte written, no BUSYWAIT; READ accepted next edge.
  - LOAD_EN pulsed during WAIT -> memory unchanged on a later readback.
- Latency parameter: READ_LATENCY=1 -> BUSYWAIT high for exactly one cycle per fetch; data correct.
